gb_lcd_pixel_packer: RTL and testbench

Downstream consumer of the DMG pixel conduit (`PX_VALID`/`LD`) at the GameBoy top level. It packs the 2-bit shade stream into bytes, four pixels per byte, and tags each byte with a frame-buffer address and a double-buffer bank. It then delivers the bytes through a small FIFO over a valid/ready write port to the display frame buffer. It absorbs frame-buffer backpressure, reports overruns, and signals frame completion so the scan-out side can swap banks.

---
 rtl/gb_video_pkg.sv | 23 ++
 rtl/gb_sync_fifo.sv | 58 +++++
 rtl/gb_lcd_pixel_packer.sv | 126 ++++++++++++
 tb/tb_gb_lcd_pixel_packer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared constants and the frame-buffer entry format for the DMG video path.
package gb_video_pkg;

    localparam int LCD_W           = 160;
    localparam int LCD_H           = 144;
    localparam int PIX_PER_BYTE    = 4;
    localparam int BYTES_PER_FRAME = (LCD_W * LCD_H) / PIX_PER_BYTE;

    localparam int FB_IDX_W  = 13;
    localparam int FB_ADDR_W = FB_IDX_W + 1;

    // One packed byte on its way to the frame buffer; bank is the MSB of the write address.
    typedef struct packed {
        logic                bank;
        logic [FB_IDX_W-1:0] idx;
        logic [7:0]          data;
    } fb_entry_t;

    function automatic logic [FB_ADDR_W-1:0] fb_addr_of(input fb_entry_t e);
        return {e.bank, e.idx};
    endfunction

endpackage

// File: rtl/gb_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO lands only when a pop frees a slot in the same cycle.
module gb_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head_data,
    output logic [WIDTH-1:0] next_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW + 1)'(DEPTH));
    assign count   = level;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers define validity, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointer increment wraps naturally.
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/gb_lcd_pixel_packer.sv
// Packs the DMG 2-bit pixel stream four-per-byte and streams addressed bytes to a double-buffered frame buffer.
module gb_lcd_pixel_packer
    import gb_video_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PIX_PER_FRAME = BYTES_PER_FRAME * PIX_PER_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 px_valid,
    input  logic [1:0]           ld,
    output logic                 fb_valid,
    input  logic                 fb_ready,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [7:0]           fb_data,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 disp_bank
);

    localparam int                  CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FB_IDX_W-1:0] LAST_IDX = FB_IDX_W'(PIX_PER_FRAME / PIX_PER_BYTE - 1);

    logic [1:0]          slot;
    logic [5:0]          acc;
    logic [FB_IDX_W-1:0] byte_idx;
    logic                wbank;

    logic                byte_done;
    logic                pop;
    logic                drop;
    fb_entry_t           push_entry;
    fb_entry_t           head_entry;
    fb_entry_t           next_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    logic                out_valid_d;
    logic                out_load;
    fb_entry_t           out_entry_d;

    assign byte_done = px_valid && (slot == 2'd3);
    assign pop       = fb_valid && fb_ready;
    assign drop      = byte_done && fifo_full && !pop;

    // acc holds the first three pixels of the group, oldest in the top bits.
    assign push_entry = '{bank: wbank, idx: byte_idx, data: {acc, ld}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot       <= '0;
            acc        <= '0;
            byte_idx   <= '0;
            wbank      <= 1'b0;
            disp_bank  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (px_valid) begin
                slot <= slot + 2'd1;
                acc  <= {acc[3:0], ld};
            end
            // Dropped bytes still advance the index so later bytes land at their true position.
            if (byte_done) begin
                if (byte_idx == LAST_IDX) begin
                    byte_idx   <= '0;
                    wbank      <= ~wbank;
                    disp_bank  <= wbank;
                    frame_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + FB_IDX_W'(1);
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

    gb_sync_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (byte_done),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (head_entry),
        .next_data (next_entry)
    );

    // The presented entry stays in the FIFO until accepted; on acceptance the entry behind it is shown directly.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        out_valid_d = fb_valid;
        out_load    = 1'b0;
        out_entry_d = head_entry;
        if (pop) begin
            out_valid_d = (fifo_count > CNT_W'(1));
            out_load    = out_valid_d;
            out_entry_d = next_entry;
        end else if (!fb_valid && !fifo_empty) begin
            out_valid_d = 1'b1;
            out_load    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fb_valid <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            fb_valid <= out_valid_d;
            if (out_load) begin
                fb_addr <= fb_addr_of(out_entry_d);
                fb_data <= out_entry_d.data;
            end
        end
    end

endmodule

// File: tb/tb_gb_lcd_pixel_packer.sv
// Directed and randomized checks of gb_lcd_pixel_packer against a byte-level reference model.
module tb_gb_lcd_pixel_packer;

    localparam int FIFO_DEPTH    = 4;
    localparam int PIX_PER_FRAME = 23040;
    localparam int BYTES         = PIX_PER_FRAME / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        px_valid = 1'b0;
    logic [1:0]  ld = 2'd0;
    logic        fb_ready = 1'b0;
    logic        fb_valid;
    logic [13:0] fb_addr;
    logic [7:0]  fb_data;
    logic        frame_done;
    logic        overflow;
    logic        disp_bank;

    gb_lcd_pixel_packer #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .PIX_PER_FRAME (PIX_PER_FRAME)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .px_valid   (px_valid),
        .ld         (ld),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .overflow   (overflow),
        .disp_bank  (disp_bank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Port monitor, sampled mid-cycle: accepted writes, frame_done pulses, stall stability.
    logic [21:0] cap_q[$];
    int          cap_t[$];
    int          fd_cnt = 0;
    int          fd_t = -1;
    logic        fd_bank = 1'b0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [21:0] prev_word = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!fb_valid || {fb_addr, fb_data} !== prev_word)) stab_err <= stab_err + 1;
            if (fb_valid && fb_ready) begin
                cap_q.push_back({fb_addr, fb_data});
                cap_t.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt  <= fd_cnt + 1;
                fd_t    <= cyc;
                fd_bank <= disp_bank;
            end
            prev_stall <= fb_valid && !fb_ready;
            prev_word  <= {fb_addr, fb_data};
        end
    end

    // Reference model: every group of four pixels becomes one byte, first pixel in the top bits.
    logic [21:0] exp_q[$];
    int          m_n = 0;
    int          m_idx = 0;
    logic        m_bank = 1'b0;
    logic [7:0]  m_byte = '0;

    function automatic void model_reset();
        m_n    = 0;
        m_idx  = 0;
        m_bank = 1'b0;
        m_byte = '0;
        exp_q.delete();
    endfunction

    function automatic void model_pixel(input logic [1:0] p);
        m_byte = m_byte | (8'(p) << (6 - 2 * m_n));
        m_n++;
        if (m_n == 4) begin
            exp_q.push_back({m_bank, 13'(m_idx), m_byte});
            m_n    = 0;
            m_byte = '0;
            m_idx++;
            if (m_idx == BYTES) begin
                m_idx  = 0;
                m_bank = ~m_bank;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] d);
        px_valid = v;
        ld       = d;
        if (v) model_pixel(d);
        @(posedge clk);
        #1;
        px_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb_valid"}, fb_valid, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_disp_bank"}, disp_bank, 0);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        px_valid = 1'b0;
        fb_ready = 1'b0;
        #1;
        check_reset_outputs({tag, "_in"});
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        check_reset_outputs({tag, "_out"});
    endtask

    task automatic drain(input int base, input int budget);
        int n = 0;
        fb_ready = 1'b1;
        while ((cap_q.size() - base) < exp_q.size() && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare_writes(input string tag, input int base);
        int got = cap_q.size() - base;
        int bad = 0;
        check({tag, "_write_count"}, got, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got; i++)
            if (cap_q[base + i] !== exp_q[i]) bad++;
        check({tag, "_write_mismatches"}, bad, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no completion, expected end of test before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t4;
        int t_last;
        int fd0;

        @(posedge clk);
        #1;

        // Single byte: 3,2,1,0 -> 0xE4 at address 0, on the port two cycles after the 4th pixel.
        do_reset("t1_rst");
        base = cap_q.size();
        fb_ready = 1'b1;
        step(1, 2'd3); step(1, 2'd2); step(1, 2'd1); step(1, 2'd0);
        t4 = cyc;
        drain(base, 10);
        compare_writes("t1", base);
        if (cap_q.size() > base) begin
            check("t1_word", cap_q[base], {14'h0000, 8'hE4});
            check("t1_latency", cap_t[base], t4 + 1);
        end

        // Pixel gaps: partial byte is held across idle cycles.
        do_reset("t2_rst");
        base = cap_q.size();
        fb_ready = 1'b1;
        step(1, 2'd1); step(0, 2'd0); step(0, 2'd0); step(1, 2'd1);
        repeat (10) step(0, 2'd3);
        step(1, 2'd1); step(1, 2'd1);
        drain(base, 10);
        compare_writes("t2", base);
        if (cap_q.size() > base) check("t2_word", cap_q[base], {14'h0000, 8'h55});

        // Full frame of shade 2, then the first byte of the next frame in bank 1.
        do_reset("t3_rst");
        base = cap_q.size();
        fd0 = fd_cnt;
        fb_ready = 1'b1;
        for (int i = 0; i < PIX_PER_FRAME; i++) step(1, 2'd2);
        t_last = cyc;
        drain(base, 20);
        compare_writes("t3_frame", base);
        if (cap_q.size() >= base + BYTES) check("t3_last_word", cap_q[base + BYTES - 1], {14'h167F, 8'hAA});
        check("t3_frame_done_count", fd_cnt - fd0, 1);
        check("t3_frame_done_cycle", fd_t, t_last);
        check("t3_disp_bank_at_done", fd_bank, 0);
        check("t3_disp_bank", disp_bank, 0);
        repeat (4) step(1, 2'd2);
        drain(base, 20);
        compare_writes("t3_next", base);
        if (cap_q.size() > base + BYTES) check("t3_next_word", cap_q[base + BYTES], {14'h2000, 8'hAA});

        // Backpressure: 40 stalled pixel cycles keep idx 0-3, drop idx 4-9.
        do_reset("t4_rst");
        base = cap_q.size();
        fb_ready = 1'b0;
        for (int i = 0; i < 40; i++) step(1, 2'($urandom));
        repeat (6) exp_q.delete(4);
        check("t4_overflow", overflow, 1);
        check("t4_stall_valid", fb_valid, 1);
        check("t4_stall_head", {fb_addr, fb_data}, exp_q[0]);
        fb_ready = 1'b1;
        for (int i = 0; i < 16; i++) step(1, 2'($urandom));
        drain(base, 40);
        compare_writes("t4", base);
        if (cap_q.size() > base + 4) check("t4_resume_idx", cap_q[base + 4][20:8], 10);
        check("t4_overflow_sticky", overflow, 1);

        // FIFO full and ready rises in the same cycle a byte completes: nothing dropped.
        do_reset("t5_rst");
        base = cap_q.size();
        fb_ready = 1'b0;
        for (int i = 0; i < 16; i++) step(1, 2'($urandom));
        repeat (3) step(0, 2'd0);
        check("t5_full_valid", fb_valid, 1);
        for (int i = 0; i < 3; i++) step(1, 2'($urandom));
        fb_ready = 1'b1;
        step(1, 2'($urandom));
        check("t5_overflow", overflow, 0);
        drain(base, 30);
        compare_writes("t5", base);
        check("t5_overflow_end", overflow, 0);

        // Reset mid-byte with three queued entries: everything discarded, restart at address 0.
        do_reset("t6_pre");
        fb_ready = 1'b0;
        for (int i = 0; i < 12; i++) step(1, 2'($urandom));
        step(1, 2'd1); step(1, 2'd2);
        do_reset("t6_rst");
        base = cap_q.size();
        fb_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 2'($urandom));
        drain(base, 10);
        compare_writes("t6", base);
        if (cap_q.size() > base) check("t6_addr", cap_q[base][21:8], 0);

        // Random gaps and random ready, a few bytes per burst so the FIFO cannot overflow.
        do_reset("t7_rst");
        base = cap_q.size();
        for (int r = 0; r < 40; r++) begin
            int npx = 4 * $urandom_range(1, 4);
            for (int k = 0; k < npx; ) begin
                fb_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) begin
                    step(0, 2'd0);
                end else begin
                    step(1, 2'($urandom));
                    k++;
                end
            end
            drain(base, 60);
        end
        compare_writes("t7", base);
        check("t7_overflow", overflow, 0);

        check("stable_under_stall", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
